// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write arbiter bus: two valid/ready writeback sources plus the
// shared regfile write port and status outputs.
//   master : the writeback sources / regfile side (drives requests)
//   slave  : the arbiter (drives ready, write port, grant, occupancy)
interface regfile_wr_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_data;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic          write_enable;
  logic [1:0]    grant;
  logic [1:0]    pend_valid;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  write_addr, write_data, write_enable, grant, pend_valid
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output write_addr, write_data, write_enable, grant, pend_valid
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares one register-file write port between the ALU
// writeback (req0) and the multicycle unit (req1). Each source has a 1-entry
// holding buffer; one buffer is drained per cycle. Default arbitration is fixed
// priority to req0 with a starvation escape for req1 after STARVE_LIMIT cycles.
// Define REGFILE_ARB_RR_EN to replace that with a 1-bit round-robin pointer.
// Writes to register 0 are drained and granted but never enable the regfile.
module regfile_wr_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 5,
  parameter int DW           = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  regfile_wr_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_0    = 2'b01,
    SEL_1    = 2'b10
  } sel_e;

  logic          buf0_full, buf1_full;
  logic [AW-1:0] buf0_addr, buf1_addr;
  logic [DW-1:0] buf0_data, buf1_data;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  logic          prefer1;
  sel_e          sel;
  logic          take0, take1;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  assign take0 = bus.req0_valid && bus.req0_ready;
  assign take1 = bus.req1_valid && bus.req1_ready;

`ifdef REGFILE_ARB_RR_EN
  logic rr_ptr;  // 1: req1 has priority on the next contended cycle

  // Round-robin pointer moves away from whichever source won a contended cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (buf0_full && buf1_full) begin
      rr_ptr <= (sel == SEL_0);
    end
  end

  assign prefer1 = rr_ptr;
`else
  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] starve_cnt, starve_nxt;

  // Starvation counter next state: count waiting cycles of a full buf1, saturate.
  always_comb begin
    starve_nxt = '0;
    if (buf1_full && (sel != SEL_1)) begin
      starve_nxt = (starve_cnt == LIMIT) ? starve_cnt : starve_cnt + 1'b1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt;
  end

  assign prefer1 = (starve_cnt == LIMIT);
`endif

  // Grant select and write-port drive; defaults first so nothing holds a latch.
  // NOTE: every signal written here gets a default before any branch; a missing
  // default on one path would infer a latch.
  always_comb begin
    sel      = SEL_NONE;
    sel_addr = last_addr;
    sel_data = last_data;
    if (buf0_full && !(buf1_full && prefer1)) begin
      sel      = SEL_0;
      sel_addr = buf0_addr;
      sel_data = buf0_data;
    end else if (buf1_full) begin
      sel      = SEL_1;
      sel_addr = buf1_addr;
      sel_data = buf1_data;
    end
  end

  // Buffer occupancy: refill wins over drain so a granted buffer can be
  // reloaded in the same cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf0_full <= 1'b0;
      buf1_full <= 1'b0;
    end else begin
      if (take0)               buf0_full <= 1'b1;
      else if (sel == SEL_0)   buf0_full <= 1'b0;
      if (take1)               buf1_full <= 1'b1;
      else if (sel == SEL_1)   buf1_full <= 1'b0;
    end
  end

  // Buffer payload capture on transfer.
  // NOTE: payload is not reset; the full flags are reset and gate every use,
  // so clearing wide data registers would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (take0) begin
      buf0_addr <= bus.req0_addr;
      buf0_data <= bus.req0_data;
    end
    if (take1) begin
      buf1_addr <= bus.req1_addr;
      buf1_data <= bus.req1_data;
    end
  end

  // Remember the last driven address/data so the idle write port holds steady.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_addr <= '0;
      last_data <= '0;
    end else if (sel != SEL_NONE) begin
      last_addr <= sel_addr;
      last_data <= sel_data;
    end
  end

  assign bus.req0_ready   = !buf0_full || (sel == SEL_0);
  assign bus.req1_ready   = !buf1_full || (sel == SEL_1);
  assign bus.grant        = sel;
  assign bus.pend_valid   = {buf1_full, buf0_full};
  assign bus.write_addr   = sel_addr;
  assign bus.write_data   = sel_data;
  assign bus.write_enable = (sel != SEL_NONE) && (sel_addr != '0);

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: scoreboard queues per source filled on each
// accepted transfer, drained and compared whenever the arbiter grants a buffer.
// A small regfile model captures the write port to check committed values.
module tb_regfile_wr_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  wr_t  q0[$];
  wr_t  q1[$];
  logic [DW-1:0] rf [32];

  regfile_wr_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  regfile_wr_arbiter #(.STARVE_LIMIT(4), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Regfile model: commits whatever the write port enables at the rising edge.
  initial for (int i = 0; i < 32; i++) rf[i] = '0;
  always @(posedge clk) if (bus.write_enable) rf[bus.write_addr] <= bus.write_data;

  // Scoreboard monitor: every grant must drain the oldest accepted entry.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (bus.grant == 2'b01 || bus.grant == 2'b10) begin
        n_tests++;
        if ((bus.grant == 2'b01 && q0.size() == 0) || (bus.grant == 2'b10 && q1.size() == 0)) begin
          n_fail++;
          $display("FAIL sb_empty: grant=%b with no pending entry expected", bus.grant);
        end else begin
          e = (bus.grant == 2'b01) ? q0.pop_front() : q1.pop_front();
          if (bus.write_addr !== e.addr || bus.write_data !== e.data ||
              bus.write_enable !== (e.addr != '0)) begin
            n_fail++;
            $display("FAIL sb_write: grant=%b got addr=%0d data=%h we=%b, expected addr=%0d data=%h we=%b",
                     bus.grant, bus.write_addr, bus.write_data, bus.write_enable,
                     e.addr, e.data, (e.addr != '0));
          end
        end
      end else if (bus.grant !== 2'b00) begin
        n_tests++;
        n_fail++;
        $display("FAIL grant_onehot: grant=%b expected one-hot or 00", bus.grant);
      end else begin
        n_tests++;
        if (bus.write_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_we: write_enable=%b expected 0 with no grant", bus.write_enable);
        end
      end
    end
  end

  task automatic idle_inputs();
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
  endtask

  task automatic check_bit(string name, logic got, logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_vec(string name, logic [DW-1:0] got, logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_drained(string name);
    n_tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_fail++;
      $display("FAIL %s: q0=%0d q1=%0d entries left, expected 0", name, q0.size(), q1.size());
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #1;
    check_bit("rst_we",     bus.write_enable, 1'b0);
    check_vec("rst_grant",  32'(bus.grant), 32'd0);
    check_vec("rst_pend",   32'(bus.pend_valid), 32'd0);
    check_vec("rst_waddr",  32'(bus.write_addr), 32'd0);
    check_vec("rst_wdata",  bus.write_data, 32'd0);
    check_bit("rst_ready0", bus.req0_ready, 1'b1);
    check_bit("rst_ready1", bus.req1_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    // Load a write, then pull reset while it sits on the write port.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'h0000_0055;
    q0.push_back('{addr: 5'd3, data: 32'h0000_0055});
    @(posedge clk);
    #1 bus.req0_valid = 1'b0;
    check_bit("mid_we_before", bus.write_enable, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_bit("mid_we",     bus.write_enable, 1'b0);
    check_vec("mid_pend",   32'(bus.pend_valid), 32'd0);
    check_bit("mid_ready0", bus.req0_ready, 1'b1);
    check_bit("mid_ready1", bus.req1_ready, 1'b1);
    q0.delete();
    q1.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_vec("mid_r3", rf[3], 32'd0);
  endtask

  task automatic test_single();
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_addr = 5'd8; bus.req0_data = 32'hDEAD_BEEF;
    q0.push_back('{addr: 5'd8, data: 32'hDEAD_BEEF});
    @(negedge clk);
    idle_inputs();
    check_bit("single_we",    bus.write_enable, 1'b1);
    check_vec("single_grant", 32'(bus.grant), 32'd1);
    check_vec("single_addr",  32'(bus.write_addr), 32'd8);
    @(negedge clk);
    check_vec("single_r8", rf[8], 32'hDEAD_BEEF);
    check_drained("single_drain");
  endtask

  task automatic test_contention();
    int i0 = 0;
    int i1 = 0;
    logic [1:0] exp_g;
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      if (c > 0) begin
`ifdef REGFILE_ARB_RR_EN
        exp_g = ((c - 1) % 2 == 1) ? 2'b10 : 2'b01;
`else
        exp_g = ((c - 1) % 5 == 4) ? 2'b10 : 2'b01;
`endif
        n_tests++;
        if (bus.grant !== exp_g) begin
          n_fail++;
          $display("FAIL cont_grant[%0d]: got %b expected %b", c, bus.grant, exp_g);
        end
      end
      if (c == 20) break;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'(i0);
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h100 + 32'(i1);
      if (bus.req0_ready) begin
        q0.push_back('{addr: 5'd1, data: 32'(i0)});
        i0++;
      end
      if (bus.req1_ready) begin
        q1.push_back('{addr: 5'd2, data: 32'h100 + 32'(i1)});
        i1++;
      end
    end
    idle_inputs();
    repeat (4) @(negedge clk);
    check_drained("cont_drain");
    check_vec("cont_pend", 32'(bus.pend_valid), 32'd0);
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'hFFFF_FFFF;
    q1.push_back('{addr: 5'd0, data: 32'hFFFF_FFFF});
    @(negedge clk);
    idle_inputs();
    check_vec("zero_grant", 32'(bus.grant), 32'd2);
    check_bit("zero_we",    bus.write_enable, 1'b0);
    @(negedge clk);
    check_vec("zero_r0", rf[0], 32'd0);
    check_drained("zero_drain");
  endtask

  task automatic test_back_to_back();
    int writes = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        check_bit($sformatf("b2b_pend[%0d]", c), bus.pend_valid[0], 1'b1);
        if (bus.write_enable) writes++;
      end
      if (c < 8) begin
        check_bit($sformatf("b2b_ready[%0d]", c), bus.req0_ready, 1'b1);
        bus.req0_valid = 1'b1;
        bus.req0_addr  = 5'(10 + c);
        bus.req0_data  = 32'hA000_0000 + 32'(c);
        q0.push_back('{addr: 5'(10 + c), data: 32'hA000_0000 + 32'(c)});
      end else begin
        idle_inputs();
      end
    end
    check_vec("b2b_writes", 32'(writes), 32'd8);
    check_bit("b2b_pend_end", bus.pend_valid[0], 1'b0);
    check_vec("b2b_hold_addr", 32'(bus.write_addr), 32'd17);
    check_vec("b2b_hold_data", bus.write_data, 32'hA000_0007);
    check_vec("b2b_r17", rf[17], 32'hA000_0007);
    check_drained("b2b_drain");
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_reg();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

endmodule
